// File: rtl/cabin_light_scheduler.sv
// cabin_light_scheduler: picks the lighting mode from the emergency, crew and
// auto-schedule requesters. Fixed priority, minimum dwell between changes,
// emergency latch.
// Optional macro CABIN_RAMP_EN: route NORMAL->IDLE through a timed DIMMING ramp.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | idle, accepts the winning crew/auto request
// ST_DWELL | holding mode_select until the dwell counter reaches 0
// ST_RAMP  | DIMMING step of a NORMAL->IDLE ramp (CABIN_RAMP_EN only)
// ST_EMERG | emergency latched; only a crew request exits
module cabin_light_scheduler #(
    parameter int MIN_DWELL   = 16,
    parameter int RAMP_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       emerg_req,
    input  logic       crew_req,
    input  logic [1:0] crew_mode,
    input  logic       auto_req,
    input  logic [1:0] auto_mode,
    output logic [1:0] mode_select,
    output logic       crew_ack,
    output logic       auto_ack,
    output logic [1:0] sched_state,
    output logic       busy,
    output logic       emerg_active
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DWELL = 2'b01,
        ST_RAMP  = 2'b10,
        ST_EMERG = 2'b11
    } state_t;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_DIM    = 2'b10;
    localparam logic [1:0] MODE_EMERG  = 2'b11;

    localparam logic [7:0] DWELL_LOAD = 8'(MIN_DWELL - 1);

    // Both parameters are range-checked even when the ramp is compiled out.
    if (MIN_DWELL < 1 || MIN_DWELL > 255 || RAMP_CYCLES < 1 || RAMP_CYCLES > 255) begin : g_bad_param
        $error("cabin_light_scheduler: MIN_DWELL and RAMP_CYCLES must be 1..255");
    end

    state_t     state, state_nxt;
    logic [1:0] mode_nxt;
    logic       crew_ack_nxt, auto_ack_nxt;
    logic [7:0] dwell_cnt, dwell_nxt;
    logic       crew_pend, auto_pend, win_valid;
    logic [1:0] win_mode;

`ifdef CABIN_RAMP_EN
    localparam logic [7:0] RAMP_LOAD = 8'(RAMP_CYCLES - 1);
    logic [7:0] ramp_cnt, ramp_nxt;
`endif

    // A request still high during its own ack cycle is the tail of the old one.
    assign crew_pend = crew_req && !crew_ack;
    assign auto_pend = auto_req && !auto_ack;
    assign win_valid = crew_pend || auto_pend;
    assign win_mode  = crew_pend ? crew_mode : auto_mode;

    assign sched_state  = state;
    assign busy         = (state == ST_DWELL) || (state == ST_RAMP);
    assign emerg_active = (state == ST_EMERG);

    // State, mode, ack and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            mode_select <= MODE_IDLE;
            crew_ack    <= 1'b0;
            auto_ack    <= 1'b0;
            dwell_cnt   <= 8'd0;
`ifdef CABIN_RAMP_EN
            ramp_cnt    <= 8'd0;
`endif
        end else begin
            state       <= state_nxt;
            mode_select <= mode_nxt;
            crew_ack    <= crew_ack_nxt;
            auto_ack    <= auto_ack_nxt;
            dwell_cnt   <= dwell_nxt;
`ifdef CABIN_RAMP_EN
            ramp_cnt    <= ramp_nxt;
`endif
        end
    end

    // Arbitration, next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_select;
        crew_ack_nxt = 1'b0;
        auto_ack_nxt = 1'b0;
        dwell_nxt    = dwell_cnt;
`ifdef CABIN_RAMP_EN
        ramp_nxt     = ramp_cnt;
`endif
        if (emerg_req) begin
            state_nxt = ST_EMERG;
            mode_nxt  = MODE_EMERG;
            dwell_nxt = 8'd0;
`ifdef CABIN_RAMP_EN
            ramp_nxt  = 8'd0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (win_valid) begin
                        crew_ack_nxt = crew_pend;
                        auto_ack_nxt = !crew_pend;
                        if (win_mode != mode_select) begin
`ifdef CABIN_RAMP_EN
                            if (win_mode == MODE_IDLE && mode_select == MODE_NORMAL) begin
                                state_nxt = ST_RAMP;
                                mode_nxt  = MODE_DIM;
                                ramp_nxt  = RAMP_LOAD;
                            end else begin
                                state_nxt = ST_DWELL;
                                mode_nxt  = win_mode;
                                dwell_nxt = DWELL_LOAD;
                            end
`else
                            state_nxt = ST_DWELL;
                            mode_nxt  = win_mode;
                            dwell_nxt = DWELL_LOAD;
`endif
                        end
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt == 8'd0) state_nxt = ST_RUN;
                    else                   dwell_nxt = dwell_cnt - 8'd1;
                end
`ifdef CABIN_RAMP_EN
                ST_RAMP: begin
                    if (ramp_cnt == 8'd0) begin
                        state_nxt = ST_DWELL;
                        mode_nxt  = MODE_IDLE;
                        dwell_nxt = DWELL_LOAD;
                    end else begin
                        ramp_nxt = ramp_cnt - 8'd1;
                    end
                end
`endif
                ST_EMERG: begin
                    if (crew_pend) begin
                        crew_ack_nxt = 1'b1;
                        mode_nxt     = crew_mode;
                        dwell_nxt    = DWELL_LOAD;
                        state_nxt    = ST_DWELL;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_cabin_light_scheduler.sv
// Directed bench for cabin_light_scheduler with default parameters
// (MIN_DWELL=16, RAMP_CYCLES=32). Ramp steps follow CABIN_RAMP_EN.
module tb_cabin_light_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       emerg_req, crew_req, auto_req;
    logic [1:0] crew_mode, auto_mode;
    logic [1:0] mode_select, sched_state;
    logic       crew_ack, auto_ack, busy, emerg_active;

    int n_pass  = 0;
    int n_total = 0;
    int cnt;

    cabin_light_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .emerg_req    (emerg_req),
        .crew_req     (crew_req),
        .crew_mode    (crew_mode),
        .auto_req     (auto_req),
        .auto_mode    (auto_mode),
        .mode_select  (mode_select),
        .crew_ack     (crew_ack),
        .auto_ack     (auto_ack),
        .sched_state  (sched_state),
        .busy         (busy),
        .emerg_active (emerg_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: let the rising edge happen, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 100; i++) begin
            if (sched_state == 2'b00) break;
            step();
        end
        chk("back_to_run", int'(sched_state), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        emerg_req = 1'b0;
        crew_req  = 1'b0;
        crew_mode = 2'b00;
        auto_req  = 1'b0;
        auto_mode = 2'b00;
        #12;
        chk("rst_mode",   int'(mode_select), 0);
        chk("rst_crewack", int'(crew_ack), 0);
        chk("rst_autoack", int'(auto_ack), 0);
        chk("rst_state",  int'(sched_state), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_emerg",  int'(emerg_active), 0);
        chk("rst_dwell",  int'(dut.dwell_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Crew NORMAL from IDLE: ack, dwell of 16 busy cycles.
        crew_req = 1'b1; crew_mode = 2'b01;
        step();
        chk("c1_ack",   int'(crew_ack), 1);
        chk("c1_mode",  int'(mode_select), 1);
        chk("c1_state", int'(sched_state), 1);
        chk("c1_busy",  int'(busy), 1);
        crew_req = 1'b0;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy) cnt++;
            else break;
        end
        chk("c1_dwell_len", cnt, 16);
        chk("c1_run", int'(sched_state), 0);

        // Same-mode request: ack only, no dwell.
        crew_req = 1'b1; crew_mode = 2'b01;
        step();
        chk("same_ack",   int'(crew_ack), 1);
        chk("same_state", int'(sched_state), 0);
        chk("same_busy",  int'(busy), 0);
        chk("same_mode",  int'(mode_select), 1);
        crew_req = 1'b0;
        step();
        chk("same_ack_pulse", int'(crew_ack), 0);

        // Crew beats auto; auto accepted MIN_DWELL+1 cycles later.
        crew_req = 1'b1; crew_mode = 2'b10;
        auto_req = 1'b1; auto_mode = 2'b01;
        step();
        chk("prio_crewack", int'(crew_ack), 1);
        chk("prio_autoack", int'(auto_ack), 0);
        chk("prio_mode",    int'(mode_select), 2);
        crew_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt++;
            if (auto_ack) break;
        end
        chk("auto_wait", cnt, 17);
        chk("auto_mode", int'(mode_select), 1);
        auto_req = 1'b0;
        wait_run();

        // NORMAL -> IDLE.
        crew_req = 1'b1; crew_mode = 2'b00;
        step();
        chk("n2i_ack", int'(crew_ack), 1);
        crew_req = 1'b0;
`ifdef CABIN_RAMP_EN
        chk("ramp_mode",  int'(mode_select), 2);
        chk("ramp_state", int'(sched_state), 2);
        cnt = 1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (mode_select == 2'b10) cnt++;
            else break;
        end
        chk("ramp_len",   cnt, 32);
        chk("ramp_idle",  int'(mode_select), 0);
        chk("ramp_dwell", int'(sched_state), 1);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy) cnt++;
            else break;
        end
        chk("ramp_dwell_len", cnt, 16);
`else
        chk("n2i_mode",  int'(mode_select), 0);
        chk("n2i_state", int'(sched_state), 1);
`endif
        wait_run();

        // Back to NORMAL, then emergency preempts a ramp/dwell in progress.
        crew_req = 1'b1; crew_mode = 2'b01;
        step();
        chk("pre_emerg_mode", int'(mode_select), 1);
        crew_req = 1'b0;
        wait_run();
`ifdef CABIN_RAMP_EN
        crew_req = 1'b1; crew_mode = 2'b00;
        step();
        crew_req = 1'b0;
        auto_req = 1'b1; auto_mode = 2'b10;
        repeat (26) step();
        chk("ramp_cnt5", int'(dut.ramp_cnt), 5);
`else
        crew_req = 1'b1; crew_mode = 2'b10;
        step();
        crew_req = 1'b0;
        auto_req = 1'b1; auto_mode = 2'b10;
        repeat (10) step();
`endif
        emerg_req = 1'b1;
        crew_req  = 1'b1; crew_mode = 2'b01;
        step();
        chk("em_mode",    int'(mode_select), 3);
        chk("em_active",  int'(emerg_active), 1);
        chk("em_state",   int'(sched_state), 3);
        chk("em_crewack", int'(crew_ack), 0);
        chk("em_autoack", int'(auto_ack), 0);
        chk("em_dwell",   int'(dut.dwell_cnt), 0);
        step();
        chk("em_hold_crewack", int'(crew_ack), 0);
        emerg_req = 1'b0;
        crew_req  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("em_auto_ignored", int'(auto_ack), 0);
            chk("em_latched", int'(sched_state), 3);
        end
        crew_req = 1'b1; crew_mode = 2'b01;
        step();
        chk("em_exit_ack",    int'(crew_ack), 1);
        chk("em_exit_auto",   int'(auto_ack), 0);
        chk("em_exit_mode",   int'(mode_select), 1);
        chk("em_exit_state",  int'(sched_state), 1);
        chk("em_exit_active", int'(emerg_active), 0);
        crew_req = 1'b0;
        auto_req = 1'b0;

        // Asynchronous reset mid-dwell; held request only acked after release.
        repeat (3) step();
        #2;
        reset_n  = 1'b0;
        crew_req = 1'b1; crew_mode = 2'b10;
        #1;
        chk("arst_mode",  int'(mode_select), 0);
        chk("arst_state", int'(sched_state), 0);
        chk("arst_busy",  int'(busy), 0);
        chk("arst_dwell", int'(dut.dwell_cnt), 0);
        step();
        chk("arst_noack", int'(crew_ack), 0);
        reset_n = 1'b1;
        step();
        chk("post_rst_ack",   int'(crew_ack), 1);
        chk("post_rst_mode",  int'(mode_select), 2);
        chk("post_rst_state", int'(sched_state), 1);
        crew_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
